// File: rtl/uncache_pkg.sv
// Shared types for the uncached data-access bridge: FSM state encoding and
// the conversion from the core's access size to an AXI size code.
package uncache_pkg;

    typedef enum logic [2:0] {
        UC_IDLE  = 3'd0,
        UC_RREQ  = 3'd1,
        UC_RWAIT = 3'd2,
        UC_WREQ  = 3'd3,
        UC_WRESP = 3'd4,
        UC_DONE  = 3'd5
    } uc_state_t;

    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/uncache.sv
// Uncached data-access bridge: turns one core load/store into a single-beat
// AXI read or write and stalls the core until the response has been consumed.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | no access in flight; captures a request when conf_en is high
//  RREQ   | read address presented, waiting for arready
//  RWAIT  | waiting for read data on rvalid
//  WREQ   | write address and data presented, each handshakes on its own
//  WRESP  | waiting for the write response on bvalid
//  DONE   | one-cycle stall release so the core takes the result
module uncache
    import uncache_pkg::*;
#(
    parameter logic [3:0] UC_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        conf_en,
    input  logic [3:0]  conf_wen,
    input  logic [1:0]  conf_size,
    input  logic [31:0] conf_addr,
    input  logic [31:0] conf_wdata,
    output logic [31:0] conf_rdata,
    output logic        stallreq,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    uc_state_t   state;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        aw_done;
    logic        w_done;

    logic aw_hs;
    logic w_hs;
    logic aw_complete;
    logic w_complete;

    assign aw_hs       = awvalid & awready;
    assign w_hs        = wvalid & wready;
    assign aw_complete = aw_done | aw_hs;
    assign w_complete  = w_done | w_hs;

    // Stall is raised in the same cycle the request appears so the core
    // never advances past an access that has not been captured yet.
    assign stallreq = ((state == UC_IDLE) && conf_en) ||
                      (state == UC_RREQ)  || (state == UC_RWAIT) ||
                      (state == UC_WREQ)  || (state == UC_WRESP);

    assign arid   = UC_ID;
    assign awid   = UC_ID;
    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arsize = axi_size(size_q);
    assign awsize = axi_size(size_q);
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign wlast  = wvalid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= UC_IDLE;
            addr_q     <= 32'h0;
            size_q     <= 2'd0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            conf_rdata <= 32'h0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            unique case (state)
                UC_IDLE: begin
                    if (conf_en) begin
                        addr_q  <= conf_addr;
                        size_q  <= conf_size;
                        wdata_q <= conf_wdata;
                        wstrb_q <= conf_wen;
                        if (conf_wen == 4'h0) begin
                            arvalid <= 1'b1;
                            state   <= UC_RREQ;
                        end else begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= UC_WREQ;
                        end
                    end
                end
                UC_RREQ: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= UC_RWAIT;
                    end
                end
                UC_RWAIT: begin
                    if (rvalid) begin
                        conf_rdata <= rdata;
                        rready     <= 1'b0;
                        state      <= UC_DONE;
                    end
                end
                UC_WREQ: begin
                    if (aw_complete && w_complete) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        bready  <= 1'b1;
                        state   <= UC_WRESP;
                    end else begin
                        if (aw_hs) begin
                            awvalid <= 1'b0;
                            aw_done <= 1'b1;
                        end
                        if (w_hs) begin
                            wvalid <= 1'b0;
                            w_done <= 1'b1;
                        end
                    end
                end
                UC_WRESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        state  <= UC_DONE;
                    end
                end
                UC_DONE: state <= UC_IDLE;
                default: state <= UC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uncache.sv
// Directed bench for the uncached access bridge: read, write in both
// handshake orders, back-to-back requests, mid-access reset and long stall.
module tb_uncache;

    logic        clk;
    logic        rst;
    logic        conf_en;
    logic [3:0]  conf_wen;
    logic [1:0]  conf_size;
    logic [31:0] conf_addr;
    logic [31:0] conf_wdata;
    logic [31:0] conf_rdata;
    logic        stallreq;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int checks   = 0;
    int failures = 0;
    int ar_cnt   = 0;
    int aw_cnt   = 0;
    int w_cnt    = 0;
    int b_cnt    = 0;

    uncache #(.UC_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .conf_en(conf_en), .conf_wen(conf_wen), .conf_size(conf_size),
        .conf_addr(conf_addr), .conf_wdata(conf_wdata), .conf_rdata(conf_rdata),
        .stallreq(stallreq),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (arvalid && arready) ar_cnt <= ar_cnt + 1;
            if (awvalid && awready) aw_cnt <= aw_cnt + 1;
            if (wvalid && wready)   w_cnt  <= w_cnt + 1;
            if (bvalid && bready)   b_cnt  <= b_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int c0;

    initial begin
        rst = 1'b1; conf_en = 1'b0; conf_wen = 4'h0; conf_size = 2'd0;
        conf_addr = 32'h0; conf_wdata = 32'h0;
        arready = 1'b0; rdata = 32'h0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        step(); step();
        chk("rst_stall", 32'(stallreq), 32'd0);
        chk("rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
        chk("rst_rdata", conf_rdata, 32'h0);
        chk("rst_addr", araddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        chk("rst_id", {24'd0, arid, awid}, 32'h11);
        rst = 1'b0;
        step();

        // Read: arready together with arvalid, rvalid two cycles later
        conf_en = 1'b1; conf_wen = 4'h0; conf_size = 2'd2; conf_addr = 32'hBFAF_8000;
        arready = 1'b1;
        #1 chk("rd_req_stall", 32'(stallreq), 32'd1);
        step();
        chk("rd_arvalid", 32'(arvalid), 32'd1);
        chk("rd_araddr", araddr, 32'hBFAF_8000);
        chk("rd_arsize", 32'(arsize), 32'd2);
        chk("rd_rreq_stall", 32'(stallreq), 32'd1);
        step();
        arready = 1'b0;
        chk("rd_ar_drop", 32'(arvalid), 32'd0);
        chk("rd_rready", 32'(rready), 32'd1);
        chk("rd_rwait_stall", 32'(stallreq), 32'd1);
        step();
        chk("rd_rwait2_stall", 32'(stallreq), 32'd1);
        rvalid = 1'b1; rdata = 32'h1234_5678;
        step();
        rvalid = 1'b0;
        chk("rd_done_stall", 32'(stallreq), 32'd0);
        chk("rd_done_rdata", conf_rdata, 32'h1234_5678);
        chk("rd_done_rready", 32'(rready), 32'd0);
        conf_en = 1'b0;
        step();
        chk("rd_idle_hold", conf_rdata, 32'h1234_5678);
        chk("rd_idle_stall", 32'(stallreq), 32'd0);

        // Write: awready at +1, wready at +3, bvalid at +5
        conf_en = 1'b1; conf_wen = 4'b0011; conf_size = 2'd1;
        conf_addr = 32'h1000_0004; conf_wdata = 32'h0000_ABCD;
        step();
        chk("wr_awvalid0", 32'(awvalid), 32'd1);
        chk("wr_wvalid0", 32'(wvalid), 32'd1);
        chk("wr_wlast0", 32'(wlast), 32'd1);
        chk("wr_wstrb", 32'(wstrb), 32'h3);
        chk("wr_wdata", wdata, 32'h0000_ABCD);
        chk("wr_awaddr", awaddr, 32'h1000_0004);
        chk("wr_awsize", 32'(awsize), 32'd1);
        step();
        chk("wr_awvalid1", 32'(awvalid), 32'd1);
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("wr_aw_drop", 32'(awvalid), 32'd0);
        chk("wr_wvalid2", 32'(wvalid), 32'd1);
        chk("wr_stall2", 32'(stallreq), 32'd1);
        step();
        chk("wr_wvalid3", 32'(wvalid), 32'd1);
        chk("wr_bready3", 32'(bready), 32'd0);
        wready = 1'b1;
        step();
        wready = 1'b0;
        chk("wr_w_drop", 32'(wvalid), 32'd0);
        chk("wr_bready4", 32'(bready), 32'd1);
        chk("wr_stall4", 32'(stallreq), 32'd1);
        step();
        chk("wr_stall5", 32'(stallreq), 32'd1);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        chk("wr_done_stall", 32'(stallreq), 32'd0);
        chk("wr_done_bready", 32'(bready), 32'd0);
        conf_en = 1'b0;
        step();

        // Write with every ready held high: single handshake each
        c0 = aw_cnt + w_cnt + b_cnt;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        conf_en = 1'b1; conf_wen = 4'hF; conf_size = 2'd2;
        conf_addr = 32'h1000_0010; conf_wdata = 32'hCAFE_F00D;
        step();
        chk("fw_wreq", {30'd0, awvalid, wvalid}, 32'h3);
        step();
        chk("fw_wresp", {29'd0, awvalid, wvalid, bready}, 32'h1);
        step();
        chk("fw_done_stall", 32'(stallreq), 32'd0);
        conf_en = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        step();
        chk("fw_hs_count", 32'(aw_cnt + w_cnt + b_cnt - c0), 32'd3);

        // Write where the data channel handshakes before the address channel
        conf_en = 1'b1; conf_wen = 4'b1100; conf_size = 2'd1;
        conf_addr = 32'h2000_0008; conf_wdata = 32'h55AA_0000;
        step();
        wready = 1'b1;
        step();
        wready = 1'b0;
        chk("wf_w_drop", 32'(wvalid), 32'd0);
        chk("wf_awvalid", 32'(awvalid), 32'd1);
        chk("wf_bready", 32'(bready), 32'd0);
        step();
        chk("wf_wvalid_low", 32'(wvalid), 32'd0);
        awready = 1'b1;
        step();
        awready = 1'b0;
        chk("wf_wresp", {29'd0, awvalid, wvalid, bready}, 32'h1);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        chk("wf_done_stall", 32'(stallreq), 32'd0);
        conf_en = 1'b0;
        step();

        // conf_en held through DONE: one AR per access, reissue only from IDLE
        c0 = ar_cnt;
        conf_en = 1'b1; conf_wen = 4'h0; conf_size = 2'd2; conf_addr = 32'h0000_0040;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0BAD_F00D;
        step();
        step();
        step();
        chk("b2b_done_stall", 32'(stallreq), 32'd0);
        chk("b2b_done_arvalid", 32'(arvalid), 32'd0);
        chk("b2b_done_rdata", conf_rdata, 32'h0BAD_F00D);
        step();
        chk("b2b_idle_arvalid", 32'(arvalid), 32'd0);
        chk("b2b_idle_stall", 32'(stallreq), 32'd1);
        chk("b2b_one_ar", 32'(ar_cnt - c0), 32'd1);
        step();
        conf_en = 1'b0;
        chk("b2b_reissue", 32'(arvalid), 32'd1);
        step();
        arready = 1'b0;
        chk("b2b_two_ar", 32'(ar_cnt - c0), 32'd2);
        step();
        rvalid = 1'b0;
        chk("b2b_done2_stall", 32'(stallreq), 32'd0);
        step();

        // Reset in RWAIT abandons the read; late rvalid ignored
        conf_en = 1'b1; conf_wen = 4'h0; conf_addr = 32'h0000_0080; arready = 1'b1;
        step();
        step();
        arready = 1'b0;
        chk("rr_rready", 32'(rready), 32'd1);
        rst = 1'b1; conf_en = 1'b0;
        step();
        rst = 1'b0;
        chk("rr_rready0", 32'(rready), 32'd0);
        chk("rr_stall0", 32'(stallreq), 32'd0);
        chk("rr_rdata0", conf_rdata, 32'h0);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0;
        chk("rr_late_rdata", conf_rdata, 32'h0);
        chk("rr_late_stall", 32'(stallreq), 32'd0);
        step();

        // arready withheld for 20 cycles
        conf_en = 1'b1; conf_wen = 4'h0; conf_size = 2'd0; conf_addr = 32'h1FC0_0013;
        step();
        for (int i = 0; i < 20; i++) begin
            chk("slow_arvalid", 32'(arvalid), 32'd1);
            chk("slow_araddr", araddr, 32'h1FC0_0013);
            chk("slow_stall", 32'(stallreq), 32'd1);
            step();
        end
        chk("slow_arsize", 32'(arsize), 32'd0);
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk("slow_ar_drop", 32'(arvalid), 32'd0);
        rvalid = 1'b1; rdata = 32'h0000_00A5;
        step();
        rvalid = 1'b0; conf_en = 1'b0;
        chk("slow_done_rdata", conf_rdata, 32'h0000_00A5);
        chk("slow_done_stall", 32'(stallreq), 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
